// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
package tdm_pkg;

   localparam int W_DEF = 8;
   localparam int N_DEF = 4;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/tdm_demux_if.sv
// Link-side word stream in, per-channel registers and status out.
interface tdm_demux_if
   import tdm_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = N_DEF
);
   logic [W-1:0]   din;
   logic           din_valid;
   logic           frame_start;
   logic [N*W-1:0] dout;
   logic [N-1:0]   dout_valid;
   logic           frame_done;
   logic           locked;
   logic           sync_err;

   modport master (
      output din, din_valid, frame_start,
      input  dout, dout_valid, frame_done, locked, sync_err
   );

   modport slave (
      input  din, din_valid, frame_start,
      output dout, dout_valid, frame_done, locked, sync_err
   );
endinterface

// File: rtl/slot_decoder.sv
// Binary slot index plus enable to one-hot channel select.
module slot_decoder #(
   parameter int N  = 4,
   parameter int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [SW-1:0] slot,
   input  logic          en,
   output logic [N-1:0]  sel
);

   always_comb begin
      sel = '0;
      if (en) sel[slot] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux.sv
// Recovers frame alignment from frame_start and routes each slot to its channel register.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = N_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   tdm_demux_if.slave  bus
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   state_e                state_q, state_d;
   logic [SW-1:0]         slot_q, slot_d, cap_slot;
   logic                  cap, fd_d, err_d;
   logic [N-1:0]          sel;
   logic [N-1:0][W-1:0]   ch_q;
   logic [N-1:0]          dv_q;
   logic                  fd_q, err_q;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      cap      = 1'b0;
      cap_slot = slot_q;
      fd_d     = 1'b0;
      err_d    = 1'b0;
      if (bus.din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (bus.frame_start) begin
                  cap      = 1'b1;
                  cap_slot = '0;
                  slot_d   = SW'(1);
                  state_d  = LOCKED;
               end
            end
            LOCKED: begin
               if (bus.frame_start) begin
                  // A marker anywhere but slot 0 truncates the frame and restarts it here.
                  err_d    = (slot_q != '0);
                  cap      = 1'b1;
                  cap_slot = '0;
                  slot_d   = SW'(1);
               end else if (slot_q == '0) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  cap = 1'b1;
                  if (slot_q == SW'(N - 1)) begin
                     fd_d   = 1'b1;
                     slot_d = '0;
                  end else begin
                     slot_d = slot_q + SW'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   slot_decoder #(.N(N), .SW(SW)) u_slot_decoder (
      .slot (cap_slot),
      .en   (cap),
      .sel  (sel)
   );

   // Capture stage: one channel write plus registered strobes per accepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         slot_q  <= '0;
         ch_q    <= '0;
         dv_q    <= '0;
         fd_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         for (int k = 0; k < N; k++) begin
            if (sel[k]) ch_q[k] <= bus.din;
         end
         dv_q  <= sel;
         fd_q  <= fd_d;
         err_q <= err_d;
      end
   end

   assign bus.dout       = ch_q;
   assign bus.dout_valid = dv_q;
   assign bus.frame_done = fd_q;
   assign bus.sync_err   = err_q;
   assign bus.locked     = (state_q == LOCKED);

endmodule
